// File: rtl/serie_paralelo_if.sv
// Serial-in / parallel-out bus for serie_paralelo.
// master = the side that streams bits in; slave = the deserializer.
interface serie_paralelo_if #(
  parameter int WIDTH = 6
);
  logic                     ena_in;
  logic                     in;
  logic [WIDTH-1:0]         out;
  logic                     ena_out;
  logic                     busy;
  logic [$clog2(WIDTH)-1:0] bit_cnt;

  modport master (
    output ena_in, in,
    input  out, ena_out, busy, bit_cnt
  );

  modport slave (
    input  ena_in, in,
    output out, ena_out, busy, bit_cnt
  );
endinterface

// File: rtl/serie_paralelo.sv
// Serial-to-parallel converter.
// Collects WIDTH serial bits into a shift register and publishes the
// finished word on out with a one-cycle ena_out pulse. In CONTINUOUS mode
// the first ena_in starts a gapless stream; otherwise each bit needs its
// own ena_in strobe and the FSM returns to IDLE after every word.
module serie_paralelo #(
  parameter int WIDTH      = 6,
  parameter bit LSB_FIRST  = 1'b1,
  parameter bit CONTINUOUS = 1'b1
) (
  input logic             clk,
  input logic             clr,
  serie_paralelo_if.slave bus
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  // NOTE: declaration initialisers give the registers their reset values at
  // power-up as well, so no word or pulse can appear before the first clr.
  state_t           state_q   = IDLE;
  logic [CW-1:0]    cnt_q     = '0;
  logic [WIDTH-1:0] sr_q      = '0;
  logic [WIDTH-1:0] out_q     = '0;
  logic             ena_out_q = 1'b0;

  state_t           state_d;
  logic [CW-1:0]    cnt_d;
  logic [WIDTH-1:0] sr_d;
  logic [WIDTH-1:0] out_d;
  logic             ena_out_d;
  logic             sample;
  logic [CW-1:0]    pos;

  // Next-state logic: decide whether this cycle samples a bit, place it, and
  // publish the word when the last bit arrives.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned; that is what keeps this block free of inferred latches.
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    out_d     = out_q;
    ena_out_d = 1'b0;

    // IDLE always waits for a strobe; RECV free-runs only in CONTINUOUS mode.
    sample = ((state_q == IDLE) || !CONTINUOUS) ? bus.ena_in : 1'b1;
    // Stream bit cnt lands at cnt (LSB first) or its mirror (MSB first).
    pos    = LSB_FIRST ? cnt_q : LAST - cnt_q;

    if (sample) begin
      sr_d[pos] = bus.in;
      if (cnt_q == LAST) begin
        // Publish the word including the bit captured this cycle.
        out_d     = sr_d;
        ena_out_d = 1'b1;
        cnt_d     = '0;
        if (CONTINUOUS) state_d = RECV;
        else            state_d = IDLE;
      end else begin
        cnt_d   = cnt_q + 1'b1;
        state_d = RECV;
      end
    end
  end

  // State register with synchronous clear; clear wins over any completion.
  always_ff @(posedge clk) begin
    // NOTE: registers are updated with non-blocking assignments so every
    // flop samples the pre-edge values, independent of statement order.
    if (clr) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sr_q      <= '0;
      out_q     <= '0;
      ena_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      out_q     <= out_d;
      ena_out_q <= ena_out_d;
    end
  end

  assign bus.out     = out_q;
  assign bus.ena_out = ena_out_q;
  assign bus.busy    = (state_q == RECV) && (cnt_q != '0);
  assign bus.bit_cnt = cnt_q;

endmodule

// File: doc/serie_paralelo.md
SERIE_PARALELO -- requirements
Module: serie_paralelo

Interface
REQ-001 Parameter WIDTH, default 6: parallel word width in bits; legal range 2..32.
REQ-002 Parameter LSB_FIRST, default 1: 1 = first serial bit maps to out[0]; 0 = first serial bit maps to out[WIDTH-1].
REQ-003 Parameter CONTINUOUS, default 1: 1 = after the first ena_in, sample a bit every cycle; 0 = sample only on cycles with ena_in=1.
REQ-004 Port list:
- clk  input  1  sole clock; all logic on its rising edge.
- clr  input  1  reset, synchronous, active-high.
- ena_in  input  1  serial-bit strobe; high marks a valid bit on in; in CONTINUOUS mode, first high marks bit 0 of the stream.
- in  input  1  serial data bit.
- out  output  WIDTH  last completed parallel word (registered).
- ena_out  output  1  one-cycle pulse: out updated with a new word.
- busy  output  1  high while a word is partially received.
- bit_cnt  output  $clog2(WIDTH)  number of bits of the current word already captured.
REQ-005 There is one clock; reset is synchronous and active-high.

Function
REQ-006 The block SHALL implement FSM states IDLE and RECV, a bit counter cnt, a WIDTH-bit shift register sr and an output register out.
REQ-007 IDLE: busy=0, cnt=0; on ena_in=1, capture in as stream bit 0, set cnt=1, enter RECV.
REQ-008 IDLE with ena_in=0: no state change; out holds.
REQ-009 RECV sample condition: CONTINUOUS=1 -> every cycle; CONTINUOUS=0 -> only cycles with ena_in=1.
REQ-010 RECV non-sample cycle (CONTINUOUS=0, ena_in=0): sr, cnt, state hold; no timeout.
REQ-011 RECV sample with cnt<WIDTH-1: capture in as stream bit cnt; cnt <= cnt+1.
REQ-012 RECV sample with cnt=WIDTH-1 (last bit): out <= complete word including this bit; ena_out=1 for exactly the following cycle; cnt <= 0.
REQ-013 After the last bit, CONTINUOUS=1: stay in RECV, so the next cycle's in is bit 0 of the next word (no gap). CONTINUOUS=0: return to IDLE.
REQ-014 Latency: ena_out and the new out are visible in the cycle immediately after the cycle in which the last bit is presented.
REQ-015 Bit mapping: LSB_FIRST=1 -> stream bit k to out[k]; LSB_FIRST=0 -> stream bit k to out[WIDTH-1-k].
REQ-016 out SHALL change only on word completion or reset; a partial word SHALL never appear on out.
REQ-017 ena_out SHALL be 0 on every cycle other than the one following completion; back-to-back words in CONTINUOUS mode produce a pulse every WIDTH cycles.
REQ-018 busy = 1 when in RECV and cnt != 0.
REQ-019 bit_cnt = cnt.
REQ-020 The block SHALL be compatible with the team's 6-bit parallel-to-serial transmitter at defaults: its out/ena_out drive in/ena_in directly, and the transmitted word is reproduced on out.

Reset
REQ-021 clr=1 at a rising edge SHALL force state=IDLE, cnt=0, sr=0, out=0, ena_out=0 and busy=0, with bit_cnt=0 following.
REQ-022 clr SHALL take priority over ena_in and over word completion in the same cycle: no ena_out pulse and no out update.
REQ-023 After clr deasserts, the block waits in IDLE for a fresh ena_in; a partial word interrupted by clr is discarded.
REQ-024 Power-up register values match the reset values in REQ-021.

Verification
REQ-025 Defaults; ena_in=1 with bits 1,0,1,1,0,1 over 6 cycles -> out=6'h2D with ena_out high for one cycle, in the cycle after bit 5; busy high during bits 1..5.
REQ-026 Defaults; continuous bits for 0x2D then 0x12 with no gap -> two ena_out pulses 6 cycles apart; out=0x2D, then 0x12.
REQ-027 CONTINUOUS=0; 6 bits of 0x15 with 1-3 idle cycles between strobes -> out=0x15 after the 6th strobe; FSM returns to IDLE; bit_cnt holds during gaps.
REQ-028 Defaults; clr pulsed after 3 bits -> out=0, busy=0, no ena_out; a following full word 0x3F -> out=0x3F.
REQ-029 LSB_FIRST=0; stream bits 1,0,0,0,0,0 -> out=6'h20.
REQ-030 clr asserted in the same cycle as the last bit -> no ena_out pulse and out=0.
